// File: rtl/link_pkg.sv
// -----------------------------------------------------------------------------
// link_pkg
//   Shared definitions for the board-to-board link (board_link and
//   link_rx_deser): frame geometry, payload bit positions, the TX/RX state
//   encodings and the parity helper.
//
//   Frame on the wire (7 bits, LSB first):
//     start=0, d0=connect, d1=start, d2=game_finish, d3=spare(0), P, stop=1
//
//   Build option: PARITY_CHECK_EN (see board_link / link_rx_deser).
// -----------------------------------------------------------------------------
package link_pkg;

    localparam int FRAME_BITS = 7;
    localparam int DATA_BITS  = 4;

    // Payload bit positions within the 4-bit data word
    localparam int D_CONNECT = 0;
    localparam int D_START   = 1;
    localparam int D_FINISH  = 2;
    localparam int D_SPARE   = 3;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_CHECK,
        RX_DATA,
        RX_PAR,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Parity bit that makes data plus P contain an even number of ones
    function automatic logic even_parity(input logic [3:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/link_rx_deser.sv
// -----------------------------------------------------------------------------
// link_rx_deser
//   Receive half of the board link: synchronises the asynchronous serial line,
//   finds start bits, samples each bit at mid-bit and checks the stop bit
//   (and, when PARITY_CHECK_EN is defined, the even parity bit).
//
//   Ports
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     line     in   serial line from peer (asynchronous to clk, idle high)
//     data     out  4-bit payload of the frame being / last received;
//                   only meaningful in the cycle valid is high
//     valid    out  1-cycle pulse: frame accepted (on the stop-sample cycle)
//     err      out  1-cycle pulse: frame rejected (stop=0 or parity mismatch)
//
//   Build option: PARITY_CHECK_EN -- reject frames whose P bit is not the
//   even parity of d0..d3. Without it the P slot is sampled and ignored.
// -----------------------------------------------------------------------------
module link_rx_deser
    import link_pkg::*;
#(
    parameter int BIT_CYCLES = 868
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 line,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 err
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);

    logic [1:0]       sync;
    logic             line_s;
    logic             line_d;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       bit_idx;
    logic             par;
    logic             sample;
    logic             parity_ok;
    logic             stop_sample;

    // Two-flop synchroniser; resets to the idle-high level so no false start
    // bit is seen when reset is released.
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync   <= 2'b11;
            line_d <= 1'b1;
        end else begin
            sync   <= {sync[0], line};
            line_d <= line_s;
        end
    end

    assign line_s = sync[1];

    // CHECK samples half a bit after the falling edge; every later sample is
    // one full bit after the previous one, which keeps them at mid-bit.
    assign sample = (state == RX_CHECK) ? (cnt == HALF_LAST) : (cnt == BIT_LAST);

`ifdef PARITY_CHECK_EN
    assign parity_ok = (par == even_parity(data));
`else
    logic par_unused;
    assign par_unused = par;
    assign parity_ok  = 1'b1;
`endif

    assign stop_sample = (state == RX_STOP) && sample;
    assign valid       = stop_sample && line_s && parity_ok;
    assign err         = stop_sample && !(line_s && parity_ok);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            data    <= '0;
            par     <= 1'b0;
        end else begin
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (line_d && !line_s) begin
                        state <= RX_CHECK;
                    end
                end
                // After a framing error the line may still be low; re-arm
                // only once it has returned high.
                RX_WAIT_HIGH: begin
                    cnt <= '0;
                    if (line_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    if (!sample) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        case (state)
                            RX_CHECK: begin
                                // Line already high again: a glitch, not a start bit
                                if (line_s) begin
                                    state <= RX_IDLE;
                                end else begin
                                    state   <= RX_DATA;
                                    bit_idx <= '0;
                                end
                            end
                            RX_DATA: begin
                                data[bit_idx] <= line_s;
                                bit_idx       <= bit_idx + 1'b1;
                                if (bit_idx == 2'(DATA_BITS - 1)) begin
                                    state <= RX_PAR;
                                end
                            end
                            RX_PAR: begin
                                par   <= line_s;
                                state <= RX_STOP;
                            end
                            RX_STOP: begin
                                state <= line_s ? RX_IDLE : RX_WAIT_HIGH;
                            end
                            default: begin
                                state <= RX_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/board_link.sv
// -----------------------------------------------------------------------------
// board_link
//   Two-board multiplayer link. Continuously serialises the local
//   connect/start/finish levels onto link_tx, deserialises the peer's frames
//   from link_rx into receive_* levels, and drops link_up (clearing receive_*)
//   when no valid frame has arrived for TIMEOUT_FRAMES frame times.
//
//   Parameters
//     BIT_CYCLES      clk cycles per bit (>= 4)
//     TIMEOUT_FRAMES  frame times without a valid frame before link loss
//
//   Ports
//     clk                  in   system clock
//     reset_n              in   asynchronous active-low reset
//     send_connect         in   local connect request (level)
//     send_start           in   local start request (level)
//     send_game_finish     in   local game finished (level)
//     link_tx              out  serial line to peer, idle high
//     link_rx              in   serial line from peer, asynchronous
//     receive_connect      out  peer connect flag
//     receive_start        out  peer start flag
//     receive_game_finish  out  peer finish flag
//     link_up              out  high while valid frames keep arriving
//     frame_err            out  1-cycle pulse per rejected rx frame
//
//   Build option: PARITY_CHECK_EN -- transmit even parity over d0..d3 and
//   reject received frames whose parity does not match. Without it P is sent
//   as 0 and ignored on receive; frame timing is identical in both builds.
// -----------------------------------------------------------------------------
module board_link
    import link_pkg::*;
#(
    parameter int BIT_CYCLES     = 868,
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic send_connect,
    input  logic send_start,
    input  logic send_game_finish,
    output logic link_tx,
    input  logic link_rx,
    output logic receive_connect,
    output logic receive_start,
    output logic receive_game_finish,
    output logic link_up,
    output logic frame_err
);

    localparam int TX_CNT_W = $clog2(BIT_CYCLES);
    localparam logic [TX_CNT_W-1:0] TX_BIT_LAST = TX_CNT_W'(BIT_CYCLES - 1);

    localparam int TO_LIMIT = TIMEOUT_FRAMES * FRAME_BITS * BIT_CYCLES;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TO_LIMIT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

    // ------------------------------------------------------------------ TX
    tx_state_t              tx_state;
    logic [TX_CNT_W-1:0]    tx_cnt;
    logic [1:0]             tx_idx;
    logic [DATA_BITS-1:0]   shadow;
    logic                   tx_par;

`ifdef PARITY_CHECK_EN
    assign tx_par = even_parity(shadow);
`else
    assign tx_par = 1'b0;
`endif

    // link_tx is a flop so the line never glitches; state changes only at
    // bit boundaries. The send_* levels are captured once per frame at the
    // start bit so a frame is always self-consistent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            shadow   <= '0;
            link_tx  <= 1'b1;
        end else if (tx_cnt != TX_BIT_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
        end else begin
            tx_cnt <= '0;
            case (tx_state)
                TX_IDLE, TX_STOP: begin
                    tx_state          <= TX_START;
                    link_tx           <= 1'b0;
                    shadow[D_CONNECT] <= send_connect;
                    shadow[D_START]   <= send_start;
                    shadow[D_FINISH]  <= send_game_finish;
                    shadow[D_SPARE]   <= 1'b0;
                end
                TX_START: begin
                    tx_state <= TX_DATA;
                    tx_idx   <= '0;
                    link_tx  <= shadow[0];
                end
                TX_DATA: begin
                    if (tx_idx == 2'(DATA_BITS - 1)) begin
                        tx_state <= TX_PAR;
                        link_tx  <= tx_par;
                    end else begin
                        tx_idx  <= tx_idx + 1'b1;
                        link_tx <= shadow[tx_idx + 2'd1];
                    end
                end
                TX_PAR: begin
                    tx_state <= TX_STOP;
                    link_tx  <= 1'b1;
                end
                default: begin
                    tx_state <= TX_IDLE;
                    link_tx  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------ RX
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_err;

    link_rx_deser #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_rx (
        .clk     (clk),
        .reset_n (reset_n),
        .line    (link_rx),
        .data    (rx_data),
        .valid   (rx_valid),
        .err     (rx_err)
    );

    // The spare payload bit carries no meaning on receive.
    logic spare_unused;
    assign spare_unused = rx_data[D_SPARE];

    // ------------------------------------------- receive flags and timeout
    logic [TO_W-1:0] to_cnt;

    // A valid frame takes priority over the timeout reaching its limit in the
    // same cycle. Once saturated the counter keeps receive_* cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            receive_connect     <= 1'b0;
            receive_start       <= 1'b0;
            receive_game_finish <= 1'b0;
            link_up             <= 1'b0;
            frame_err           <= 1'b0;
            to_cnt              <= '0;
        end else begin
            frame_err <= rx_err;
            if (rx_valid) begin
                receive_connect     <= rx_data[D_CONNECT];
                receive_start       <= rx_data[D_START];
                receive_game_finish <= rx_data[D_FINISH];
                link_up             <= 1'b1;
                to_cnt              <= '0;
            end else begin
                if (to_cnt != TO_MAX) begin
                    to_cnt <= to_cnt + 1'b1;
                end
                if (to_cnt >= TO_LAST) begin
                    receive_connect     <= 1'b0;
                    receive_start       <= 1'b0;
                    receive_game_finish <= 1'b0;
                    link_up             <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_link.sv
// -----------------------------------------------------------------------------
// tb_board_link
//   Directed self-checking bench for board_link with BIT_CYCLES=8 and
//   TIMEOUT_FRAMES=2 (frame = 56 clk, timeout = 112 clk). link_tx is looped
//   to link_rx unless the bench drives its own line. Outputs are sampled on
//   the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_board_link;

    localparam int BIT_CYCLES     = 8;
    localparam int TIMEOUT_FRAMES = 2;
    localparam int FRAME_CYCLES   = 7 * BIT_CYCLES;
    localparam int TIMEOUT_CYCLES = TIMEOUT_FRAMES * FRAME_CYCLES;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic send_connect = 1'b0;
    logic send_start = 1'b0;
    logic send_game_finish = 1'b0;
    logic link_tx;
    logic link_rx;
    logic receive_connect;
    logic receive_start;
    logic receive_game_finish;
    logic link_up;
    logic frame_err;

    logic loop_en  = 1'b1;
    logic inj_line = 1'b1;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;

    assign link_rx = loop_en ? link_tx : inj_line;

    always #5 clk = ~clk;

    board_link #(
        .BIT_CYCLES     (BIT_CYCLES),
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .send_connect        (send_connect),
        .send_start          (send_start),
        .send_game_finish    (send_game_finish),
        .link_tx             (link_tx),
        .link_rx             (link_rx),
        .receive_connect     (receive_connect),
        .receive_start       (receive_start),
        .receive_game_finish (receive_game_finish),
        .link_up             (link_up),
        .frame_err           (frame_err)
    );

    // Counts cycles in which frame_err is high
    always @(negedge clk) begin
        if (reset_n && frame_err === 1'b1) begin
            err_pulses++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {stop, P, d3..d0, start}
    function automatic logic [6:0] make_frame(input logic [3:0] d, input logic stop,
                                              input logic flip_par);
        logic p;
`ifdef PARITY_CHECK_EN
        p = ^d;
`else
        p = 1'b0;
`endif
        return {stop, p ^ flip_par, d, 1'b0};
    endfunction

    // Called at a falling edge; drives each bit for BIT_CYCLES clocks
    task automatic send_frame(input logic [6:0] f);
        for (int i = 0; i < 7; i++) begin
            inj_line = f[i];
            repeat (BIT_CYCLES) @(negedge clk);
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   base;
        logic hit;
        logic prev_tx;

        // ---------------------------------------------------------- reset
        repeat (3) @(negedge clk);
        check("rst_link_tx", link_tx, 1);
        check("rst_rx_connect", receive_connect, 0);
        check("rst_rx_start", receive_start, 0);
        check("rst_rx_finish", receive_game_finish, 0);
        check("rst_link_up", link_up, 0);
        check("rst_frame_err", frame_err, 0);

        // ------------------------------------------- 1: connect over loop
        send_connect = 1'b1;
        reset_n = 1'b1;
        n = 0;
        while (!(link_up === 1'b1 && receive_connect === 1'b1) && n < TIMEOUT_CYCLES) begin
            @(negedge clk);
            n++;
        end
        check("connect_within_2_frames", {link_up, receive_connect}, 2'b11);
        check("connect_rx_start", receive_start, 0);
        check("connect_rx_finish", receive_game_finish, 0);

        // ------------------------------------------ 2: toggle send_start
        repeat (20) @(negedge clk);
        send_start = 1'b1;
        n = 0;
        while (receive_start !== 1'b1 && n < TIMEOUT_CYCLES) begin
            @(negedge clk);
            n++;
        end
        check("start_rise_within_2_frames", receive_start, 1);
        check("start_rise_connect_kept", receive_connect, 1);
        repeat (23) @(negedge clk);
        send_start = 1'b0;
        n = 0;
        while (receive_start !== 1'b0 && n < TIMEOUT_CYCLES) begin
            @(negedge clk);
            n++;
        end
        check("start_fall_within_2_frames", receive_start, 0);
        check("toggle_no_frame_err", err_pulses, 0);

        // --------------------------------------------- 3: timeout
        // Break the loop at a TX start bit: the previous frame (valid one
        // cycle before that start bit) is then the last one received.
        prev_tx = link_tx;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 2 * FRAME_CYCLES) begin
            @(negedge clk);
            hit = (prev_tx === 1'b1 && link_tx === 1'b0);
            prev_tx = link_tx;
            n++;
        end
        check("tx_start_bit_seen", hit, 1);
        loop_en  = 1'b0;
        inj_line = 1'b1;
        repeat (TIMEOUT_CYCLES - 2) @(negedge clk);
        check("timeout_not_early_link_up", link_up, 1);
        check("timeout_not_early_connect", receive_connect, 1);
        @(negedge clk);
        check("timeout_link_up", link_up, 0);
        check("timeout_rx_connect", receive_connect, 0);
        check("timeout_rx_start", receive_start, 0);
        check("timeout_rx_finish", receive_game_finish, 0);

        // ----------------------------------------- 4: stop=0 frame
        send_frame(make_frame(4'b0101, 1'b1, 1'b0));
        check("good1_connect", receive_connect, 1);
        check("good1_start", receive_start, 0);
        check("good1_finish", receive_game_finish, 1);
        check("good1_link_up", link_up, 1);
        base = err_pulses;
        send_frame(make_frame(4'b0010, 1'b0, 1'b0));
        inj_line = 1'b1;
        repeat (4) @(negedge clk);
        check("stop0_err_one_cycle", err_pulses - base, 1);
        check("stop0_hold_connect", receive_connect, 1);
        check("stop0_hold_start", receive_start, 0);
        check("stop0_hold_finish", receive_game_finish, 1);
        send_frame(make_frame(4'b0110, 1'b1, 1'b0));
        check("good2_connect", receive_connect, 0);
        check("good2_start", receive_start, 1);
        check("good2_finish", receive_game_finish, 1);
        check("good2_link_up", link_up, 1);

        // ------------------------------------------ 5: glitch / parity
        base = err_pulses;
        inj_line = 1'b0;
        repeat (3) @(negedge clk);
        inj_line = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_no_err", err_pulses - base, 0);
        check("glitch_connect", receive_connect, 0);
        check("glitch_start", receive_start, 1);
        check("glitch_finish", receive_game_finish, 1);
`ifdef PARITY_CHECK_EN
        send_frame(make_frame(4'b0001, 1'b1, 1'b1));
        repeat (4) @(negedge clk);
        check("parity_err", err_pulses - base, 1);
        check("parity_hold_connect", receive_connect, 0);
        check("parity_hold_start", receive_start, 1);
        check("parity_hold_finish", receive_game_finish, 1);
`endif

        // ---------------------------------------- 6: reset mid-frame
        // Reconnect the loop exactly at a TX start bit so the first frame
        // seen is complete.
        prev_tx = link_tx;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 2 * FRAME_CYCLES) begin
            @(negedge clk);
            hit = (prev_tx === 1'b1 && link_tx === 1'b0);
            prev_tx = link_tx;
            n++;
        end
        loop_en = 1'b1;
        check("reloop_start_seen", hit, 1);
        n = 0;
        while (!(link_up === 1'b1 && receive_connect === 1'b1) && n < TIMEOUT_CYCLES) begin
            @(negedge clk);
            n++;
        end
        check("reloop_link_up", {link_up, receive_connect}, 2'b11);
        check("reloop_start", receive_start, 0);
        check("reloop_finish", receive_game_finish, 0);
        base = err_pulses;

        prev_tx = link_tx;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 2 * FRAME_CYCLES) begin
            @(negedge clk);
            hit = (prev_tx === 1'b1 && link_tx === 1'b0);
            prev_tx = link_tx;
            n++;
        end
        repeat (3) @(negedge clk);
        check("pre_reset_tx_low", link_tx, 0);
        reset_n = 1'b0;
        #1;
        check("async_rst_link_tx", link_tx, 1);
        check("async_rst_connect", receive_connect, 0);
        check("async_rst_start", receive_start, 0);
        check("async_rst_finish", receive_game_finish, 0);
        check("async_rst_link_up", link_up, 0);
        check("async_rst_frame_err", frame_err, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (!(link_up === 1'b1 && receive_connect === 1'b1) && n < TIMEOUT_CYCLES) begin
            @(negedge clk);
            n++;
        end
        check("post_reset_link_up", {link_up, receive_connect}, 2'b11);
        check("post_reset_start", receive_start, 0);
        check("post_reset_no_err", err_pulses - base, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
